// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// bit-period helpers reused by the transmitter and the future receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // A 1-bit floor keeps the counter legal even when the divider is rejected.
  function automatic int calc_cnt_width(input int clk_freq, input int baud_rate);
    int div;
    div = clk_freq / baud_rate;
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word handshake between a data source and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Divide-by-DIV bit-period counter; held at zero while disabled and ticks
// on the last cycle of every bit period.
module uart_baud_gen #(
  parameter int DIV   = 10,
  parameter int CNT_W = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: holding register behind a valid/ready
// handshake, LSB-first shifter, optional parity and 1 or 2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  uart_tx_cfg_if.slave  bus,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = calc_cnt_width(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic                 hold_full;
  logic                 par_q, par_next;
  logic [3:0]           bit_cnt, bit_cnt_next;
  logic                 tick;
  logic                 accept;
  logic                 transfer;
  logic                 done;
  logic                 tx_next;

  assign accept       = bus.tx_valid && !hold_full;
  assign bus.tx_ready = !hold_full;
  assign tx_busy      = (state != ST_IDLE);
  assign tx_done      = done;

  uart_baud_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_baud_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tx_busy),
    .tick    (tick)
  );

  // The line value is derived from the next state so tx can be a flop
  // that changes on the same edge as the state it represents.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_q;
    par_next     = par_q;
    transfer     = 1'b0;
    done         = 1'b0;
    tx_next      = 1'b1;

    case (state)
      ST_IDLE: begin
        if (hold_full) transfer = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = 4'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = shift_q >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = 4'd0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next   = ST_STOP;
          bit_cnt_next = 4'd0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            done         = 1'b1;
            bit_cnt_next = 4'd0;
            if (hold_full) transfer = 1'b1;
            else           state_next = ST_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (transfer) begin
      state_next   = ST_START;
      bit_cnt_next = 4'd0;
      shift_next   = hold_q;
      par_next     = (^hold_q) ^ (PARITY == PAR_ODD);
    end

    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase
  end

  // A new accept wins over a transfer so a word arriving on the transfer
  // edge stays held while the previous one moves to the shifter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift_q <= shift_next;
      par_q   <= par_next;
      tx      <= tx_next;
      if (accept) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations (8N1, 8E2, 8O2, 5N1)
// at DIV = 10, with frames described as bit strings in line order.
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] valid;
  logic [8:0] data [4];
  wire  [3:0] line;
  wire  [3:0] busy;
  wire  [3:0] done;
  wire  [3:0] ready;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if3 ();

  assign if0.tx_valid = valid[0];
  assign if1.tx_valid = valid[1];
  assign if2.tx_valid = valid[2];
  assign if3.tx_valid = valid[3];
  assign if0.tx_data  = data[0][7:0];
  assign if1.tx_data  = data[1][7:0];
  assign if2.tx_data  = data[2][7:0];
  assign if3.tx_data  = data[3][4:0];
  assign ready[0]     = if0.tx_ready;
  assign ready[1]     = if1.tx_ready;
  assign ready[2]     = if2.tx_ready;
  assign ready[3]     = if3.tx_ready;

  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if0), .tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
    dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if1), .tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    dut2 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if2), .tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1))
    dut3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if3), .tx(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic logic exp_line(input string s, input int k);
    return (s[k / DIV] == "1");
  endfunction

  task automatic test_reset();
    sys_rst = 1'b1;
    valid   = 4'b0000;
    for (int i = 0; i < 4; i++) data[i] = 9'h000;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (line[i] !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx dut%0d got=%b exp=1", i, line[i]); end
      checks++;
      if (ready[i] !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready dut%0d got=%b exp=1", i, ready[i]); end
      checks++;
      if (busy[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy dut%0d got=%b exp=0", i, busy[i]); end
      checks++;
      if (done[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_done dut%0d got=%b exp=0", i, done[i]); end
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_single_frame(input int sel, input logic [8:0] word, input string exp, input string name);
    int n, bad_line, first_line, bad_done, bad_busy;
    n = exp.len() * DIV;
    bad_line = 0; first_line = -1; bad_done = 0; bad_busy = 0;
    @(negedge sys_clk);
    data[sel]  = word;
    valid[sel] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid[sel] = 1'b0;
    checks++;
    if (ready[sel] !== 1'b0) begin failures++; $display("[TB] FAIL %s_ready_held got=%b exp=0", name, ready[sel]); end
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (line[sel] !== exp_line(exp, k)) begin
        if (bad_line == 0) first_line = k;
        bad_line++;
      end
      if (done[sel] !== (k == n - 1)) bad_done++;
      if (busy[sel] !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_line != 0) begin failures++; $display("[TB] FAIL %s_line bad_cycles=%0d first_bad_cycle=%0d exp_bits=%s", name, bad_line, first_line, exp); end
    checks++;
    if (bad_done != 0) begin failures++; $display("[TB] FAIL %s_done bad_cycles=%0d exp=single pulse at cycle %0d", name, bad_done, n - 1); end
    checks++;
    if (bad_busy != 0) begin failures++; $display("[TB] FAIL %s_busy bad_cycles=%0d exp=1 for %0d cycles", name, bad_busy, n); end
    @(negedge sys_clk);
    checks++;
    if (busy[sel] !== 1'b0 || line[sel] !== 1'b1 || ready[sel] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_idle_after busy=%b tx=%b ready=%b exp busy=0 tx=1 ready=1", name, busy[sel], line[sel], ready[sel]);
    end
  endtask

  task automatic test_back_to_back();
    string exp;
    int bad_line, bad_done, bad_busy, bad_ready;
    logic exp_ready;
    exp = {"0101010101", "0110011001"};
    bad_line = 0; bad_done = 0; bad_busy = 0; bad_ready = 0;
    @(negedge sys_clk);
    data[0]  = 9'h055;
    valid[0] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (ready[0] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_first_held got=%b exp=0", ready[0]); end
    data[0] = 9'h033;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      exp_ready = (k == 0) || (k >= 100);
      if (ready[0] !== exp_ready) bad_ready++;
      if (line[0] !== exp_line(exp, k)) bad_line++;
      if (done[0] !== (k == 99 || k == 199)) bad_done++;
      if (busy[0] !== 1'b1) bad_busy++;
      if (k == 1) valid[0] = 1'b0;
    end
    checks++;
    if (bad_line != 0) begin failures++; $display("[TB] FAIL b2b_line bad_cycles=%0d exp_bits=%s", bad_line, exp); end
    checks++;
    if (bad_done != 0) begin failures++; $display("[TB] FAIL b2b_done bad_cycles=%0d exp=pulses at cycles 99 and 199", bad_done); end
    checks++;
    if (bad_busy != 0) begin failures++; $display("[TB] FAIL b2b_busy bad_cycles=%0d exp=1 with no gap", bad_busy); end
    checks++;
    if (bad_ready != 0) begin failures++; $display("[TB] FAIL b2b_ready bad_cycles=%0d exp=0 only while held", bad_ready); end
    @(negedge sys_clk);
    checks++;
    if (busy[0] !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_after busy=%b exp=0", busy[0]); end
  endtask

  task automatic test_reset_mid_frame();
    int bad_line, bad_done, bad_busy;
    bad_line = 0; bad_done = 0; bad_busy = 0;
    @(negedge sys_clk);
    data[0]  = 9'h0A5;
    valid[0] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid[0] = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        data[0]  = 9'h0FF;
        valid[0] = 1'b1;
      end
      if (k == 2) begin
        checks++;
        if (ready[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_word_held ready=%b exp=0", ready[0]); end
        valid[0] = 1'b0;
      end
    end
    checks++;
    if (line[0] !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_data_bit3 tx=%b exp=0", line[0]); end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++;
    if (line[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_after tx=%b ready=%b busy=%b done=%b exp tx=1 ready=1 busy=0 done=0", line[0], ready[0], busy[0], done[0]);
    end
    for (int k = 0; k < 150; k++) begin
      @(negedge sys_clk);
      if (line[0] !== 1'b1) bad_line++;
      if (done[0] !== 1'b0) bad_done++;
      if (busy[0] !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_line != 0 || bad_done != 0 || bad_busy != 0) begin
      failures++;
      $display("[TB] FAIL rst_mid_held_word_discarded tx_low=%0d done_high=%0d busy_high=%0d exp all 0", bad_line, bad_done, bad_busy);
    end
  endtask

  task automatic test_valid_while_full();
    string exp;
    int bad_line, bad_done, bad_ready;
    logic exp_ready;
    exp = {"0111100001", "0100000011", "0001111001"};
    bad_line = 0; bad_done = 0; bad_ready = 0;
    @(negedge sys_clk);
    data[0]  = 9'h00F;
    valid[0] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid[0] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      exp_ready = (k <= 1) || (k == 100) || (k >= 200);
      if (ready[0] !== exp_ready) bad_ready++;
      if (line[0] !== exp_line(exp, k)) bad_line++;
      if (done[0] !== (k == 99 || k == 199 || k == 299)) bad_done++;
      case (k)
        1:   begin data[0] = 9'h081; valid[0] = 1'b1; end
        2:   data[0] = 9'h0C3;
        50:  data[0] = 9'h03C;
        101: valid[0] = 1'b0;
        default: ;
      endcase
    end
    checks++;
    if (bad_line != 0) begin failures++; $display("[TB] FAIL ignore_line bad_cycles=%0d exp_bits=%s", bad_line, exp); end
    checks++;
    if (bad_done != 0) begin failures++; $display("[TB] FAIL ignore_done bad_cycles=%0d exp=pulses at 99,199,299", bad_done); end
    checks++;
    if (bad_ready != 0) begin failures++; $display("[TB] FAIL ignore_ready bad_cycles=%0d exp=0 while held", bad_ready); end
    @(negedge sys_clk);
    checks++;
    if (busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ignore_idle_after busy=%b ready=%b exp busy=0 ready=1", busy[0], ready[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(0, 9'h0A5, "0101001011",   "8n1_a5");
    test_single_frame(0, 9'h000, "0000000001",   "8n1_00");
    test_single_frame(0, 9'h0FF, "0111111111",   "8n1_ff");
    test_single_frame(1, 9'h007, "011100000111", "8e2_07");
    test_single_frame(1, 9'h000, "000000000011", "8e2_00");
    test_single_frame(2, 9'h007, "011100000011", "8o2_07");
    test_single_frame(2, 9'h000, "000000000111", "8o2_00");
    test_single_frame(3, 9'h1FF, "0111111",      "5n1_1f");
    test_single_frame(3, 9'h0EB, "0110101",      "5n1_0b");
    test_back_to_back();
    test_reset_mid_frame();
    test_valid_while_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the next generation of the project's fixed 8N1 transmitter. Serialises DATA_BITS-wide words LSB first with optional even/odd parity and 1 or 2 stop bits, at a bit period derived from CLK_FREQ/BAUD_RATE. A one-word holding register behind a valid/ready handshake allows back-to-back frames with no idle gap. It sits between protocol/packet logic and the board TX pin.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- BAUD_RATE, 115_200: line rate; DIV = CLK_FREQ / BAUD_RATE (integer division, truncated); must be ≥ 2, otherwise elaboration error.
- DATA_BITS, 8: data bits per frame, legal range 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- sys_clk  in  1  single clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_BITS  word to send; sampled on accept.
- tx_valid  in  1  word on tx_data is valid.
- tx_ready  out  1  holding register empty; accept = tx_valid & tx_ready.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  a frame is on the line (state ≠ IDLE).
- tx_done  out  1  one-cycle pulse at the last cycle of the final stop bit.

## Operation
- Reset values: tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0; holding register empty; state IDLE; counters 0.
- Reset asserted mid-frame aborts the frame: tx = 1 from the next edge, and the held word is discarded.
- Holding register: on accept, tx_data is loaded and marked full. The shifter takes the word when state is IDLE, or on the last cycle of the final stop bit (back-to-back). The holding register clears on transfer.
- Accept and transfer in the same cycle are legal: the new word is held, and the old word moves to the shifter.
- FSM states: IDLE → START → DATA → (PARITY if PARITY ≠ 0) → STOP → IDLE, or STOP → START directly when the holding register is full at the end of the frame.
- START drives 0. DATA drives shift[0], shifting right each bit, for DATA_BITS bits. PARITY drives the computed parity bit. STOP drives 1 for STOP_BITS bits.
- Parity: even = XOR of the data bits; odd = its inverse. It is computed over the DATA_BITS bits latched into the shifter.
- Baud counter runs 0..DIV-1 and is held at 0 in IDLE. Every bit occupies exactly DIV cycles; the bit counter advances on the terminal count.
- tx_valid with tx_ready = 0 is ignored. The source must hold tx_data and tx_valid until accepted.

## Timing
- Accept on edge E0 with state IDLE: the shifter loads and the state enters START at E1, and tx = 0 after E1.
- Frame length: DIV × (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) cycles.
- tx_done is high for the single cycle in which the final stop bit's counter equals DIV-1.
- Back-to-back: the next start bit begins on the edge immediately after tx_done, with zero idle cycles.
- tx_ready returns to 1 the cycle after the transfer into the shifter. This lets a second word be accepted during the first frame.
- Latency from accept to the first line transition is 1 cycle. Throughput is one frame per frame length.

## Structure
- Package uart_pkg holds:
  - the parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD);
  - the state encoding;
  - a constant function computing DIV and its counter width ($clog2(DIV)), to be shared with the future uart_rx_cfg.
- One sub-module, uart_baud_gen: the divide-by-DIV counter with enable and a terminal-count tick output.
- The FSM, holding register, shifter and parity logic live in the top module.

## Test plan
Unless stated otherwise, CLK_FREQ = 50_000_000 and BAUD_RATE = 5_000_000 (DIV = 10).
- 8N1, send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 cycles. tx_done pulses at cycle 100 after the start bit begins. tx_busy then drops.
- PARITY = 1, STOP_BITS = 2, send 0x07 → parity bit 1, then two stop bits; frame is 120 cycles. With PARITY = 2 the parity bit is 0.
- DATA_BITS = 5, send 0x1F (upper input bits are don't-care) → 5 ones after the start bit, then stop; frame is 70 cycles.
- Back-to-back: tx_valid held high with 0x55, then 0x33 presented after the first accept → the second start bit follows tx_done with zero gap, and tx_ready is 0 only while the holding register is full.
- Reset mid-frame (sys_rst during data bit 3, with a word held) → tx = 1 the next cycle, tx_ready = 1, no tx_done, and the held word is never transmitted.
- tx_valid asserted while tx_ready = 0 → word not captured; the data changing before acceptance is sent as the final value.
